// File: rtl/program_counter.sv
// Program counter: a single WIDTH-bit register that loads a jump target,
// increments by one, or holds. Priority is reset, then load, then increment.
module program_counter #(
  parameter int unsigned           WIDTH        = 12,
  parameter logic [WIDTH-1:0]      RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loadPC,
  input  logic             incPC,
  input  logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] execadd
);

  localparam int unsigned PC_W = WIDTH;

  logic [PC_W-1:0] pc_next_c;

  // Next-PC selection; the increment wraps naturally at 2^WIDTH.
  always_comb begin
    pc_next_c = execadd;
    if (loadPC) begin
      pc_next_c = address;
    end else if (incPC) begin
      pc_next_c = execadd + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      execadd <= RESET_VECTOR;
    end else begin
      execadd <= pc_next_c;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: the driver queues expected PC values,
// a monitor pops and compares them at each falling edge or on demand.
module tb_program_counter;

  localparam int unsigned W = 12;

  logic         clk;
  logic         rst_n;
  logic         loadPC;
  logic         incPC;
  logic [W-1:0] address;
  logic [W-1:0] execadd;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  event         probe;

  program_counter #(.WIDTH(W), .RESET_VECTOR(12'h000)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .loadPC  (loadPC),
    .incPC   (incPC),
    .address (address),
    .execadd (execadd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: the PC has no valid strobe, so it is sampled every falling edge
  // (or immediately on a probe) whenever an expectation is pending.
  initial begin
    logic [W-1:0] e;
    string        n;
    forever begin
      @(negedge clk or probe);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (execadd !== e) begin
          bad++;
          $display("FAIL %s: execadd=%h expected=%h at %0t", n, execadd, e, $time);
        end
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Drive controls mid-cycle, then queue the value expected after the next edge.
  task automatic step(input logic ld, input logic inc, input logic [W-1:0] a,
                      input logic [W-1:0] e, input string n);
    @(negedge clk);
    #1;
    loadPC  = ld;
    incPC   = inc;
    address = a;
    @(posedge clk);
    push_exp(e, n);
  endtask

  // Check without waiting for a clock edge.
  task automatic now_chk(input logic [W-1:0] e, input string n);
    push_exp(e, n);
    -> probe;
  endtask

  initial begin
    rst_n   = 1'b1;
    loadPC  = 1'b0;
    incPC   = 1'b0;
    address = 12'h000;

    // Reset takes effect before the first clock edge.
    #1 rst_n = 1'b0;
    #1 now_chk(12'h000, "rst_async");

    // Controls are ignored while reset is held.
    step(1'b1, 1'b1, 12'h123, 12'h000, "rst_hold_ld");
    step(1'b0, 1'b1, 12'h123, 12'h000, "rst_hold_inc");
    @(negedge clk);
    #1;
    loadPC = 1'b0;
    incPC  = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h000, 12'h000, "idle_hold");

    // Load, then hold while address moves.
    step(1'b1, 1'b0, 12'h003, 12'h003, "load_003");
    step(1'b0, 1'b0, 12'h004, 12'h003, "hold_addr_chg");
    step(1'b0, 1'b0, 12'h7FF, 12'h003, "hold_addr_chg2");

    // Five increments.
    step(1'b0, 1'b1, 12'h7FF, 12'h004, "inc_004");
    step(1'b0, 1'b1, 12'h7FF, 12'h005, "inc_005");
    step(1'b0, 1'b1, 12'h7FF, 12'h006, "inc_006");
    step(1'b0, 1'b1, 12'h7FF, 12'h007, "inc_007");
    step(1'b0, 1'b1, 12'h7FF, 12'h008, "inc_008");

    // Load beats increment on every edge.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 12'h005, 12'h005, "prio_load");
    step(1'b0, 1'b1, 12'h005, 12'h006, "prio_inc_006");
    step(1'b0, 1'b1, 12'h005, 12'h007, "prio_inc_007");

    // Wrap at the top of the address space.
    step(1'b1, 1'b0, 12'hFFE, 12'hFFE, "wrap_load");
    step(1'b0, 1'b1, 12'h000, 12'hFFF, "wrap_fff");
    step(1'b0, 1'b1, 12'h000, 12'h000, "wrap_000");
    step(1'b0, 1'b1, 12'h000, 12'h001, "wrap_001");

    // Reset dropped between edges while incrementing from 0A0.
    step(1'b1, 1'b0, 12'h0A0, 12'h0A0, "load_0a0");
    @(negedge clk);
    #1;
    loadPC = 1'b0;
    incPC  = 1'b1;
    #1 rst_n = 1'b0;
    #1 now_chk(12'h000, "rst_mid_async");
    @(posedge clk);
    push_exp(12'h000, "rst_mid_hold1");
    @(posedge clk);
    push_exp(12'h000, "rst_mid_hold2");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    push_exp(12'h001, "rst_release_inc");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
